// File: rtl/conware_scheduler.sv
// Run-control sequencer for a Game-of-Life board: seeds, feeds a compute engine, streams results to a display.
// Optional inter-frame delay is compiled in with `define CONWARE_SCHED_FRAME_DELAY_EN.
module conware_scheduler #(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4,
  parameter int CWIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      step,
  input  logic                      stop,
  input  logic [CWIDTH-1:0]         gen_limit,
  input  logic [CWIDTH-1:0]         frame_delay,
  input  logic [WIDTH*HEIGHT-1:0]   seed_data,
  input  logic                      seed_valid,
  output logic                      seed_ready,
  output logic [WIDTH*HEIGHT-1:0]   calc_data,
  output logic                      calc_valid,
  input  logic                      calc_ready,
  input  logic [WIDTH*HEIGHT-1:0]   res_data,
  input  logic                      res_valid,
  output logic                      res_ready,
  output logic [WIDTH*HEIGHT-1:0]   disp_data,
  output logic                      disp_valid,
  input  logic                      disp_ready,
  output logic                      busy,
  output logic [CWIDTH-1:0]         gen_count
);

  localparam int CELLS = WIDTH * HEIGHT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_COMPUTE,
    S_CWAIT
`ifdef CONWARE_SCHED_FRAME_DELAY_EN
    , S_DELAY
`endif
  } state_t;

  state_t              state;
  logic [CELLS-1:0]    board;
  logic                run;
  logic                limit_zero;
  logic [CWIDTH-1:0]   target;

`ifdef CONWARE_SCHED_FRAME_DELAY_EN
  logic [CWIDTH-1:0]   delay_cnt;
`else
  logic                unused_frame_delay;
  assign unused_frame_delay = ^frame_delay;
`endif

  // Handshake flags decode straight from the state register, so they change only on clock edges.
  assign seed_ready = (state == S_IDLE);
  assign calc_valid = (state == S_COMPUTE);
  assign res_ready  = (state == S_CWAIT);
  assign disp_valid = (state == S_EMIT);
  assign busy       = (state != S_IDLE);
  assign calc_data  = board;
  assign disp_data  = board;

  // NOTE: reset is sampled on the clock edge (synchronous); every state register, the board included, is cleared.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      board      <= '0;
      gen_count  <= '0;
      run        <= 1'b0;
      limit_zero <= 1'b0;
      target     <= '0;
`ifdef CONWARE_SCHED_FRAME_DELAY_EN
      delay_cnt  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (seed_valid) begin
            board     <= seed_data;
            gen_count <= '0;
            run       <= 1'b0;
            state     <= S_EMIT;
          end else if (start && !stop) begin
            run        <= 1'b1;
            target     <= gen_count + gen_limit;
            limit_zero <= (gen_limit == '0);
            state      <= S_COMPUTE;
          end else if (step) begin
            run   <= 1'b0;
            state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          if (calc_ready) state <= S_CWAIT;
        end
        S_CWAIT: begin
          if (res_valid) begin
            board     <= res_data;
            gen_count <= gen_count + 1'b1;
`ifdef CONWARE_SCHED_FRAME_DELAY_EN
            if (frame_delay != '0) begin
              delay_cnt <= frame_delay;
              state     <= S_DELAY;
            end else begin
              state <= S_EMIT;
            end
`else
            state <= S_EMIT;
`endif
          end
        end
`ifdef CONWARE_SCHED_FRAME_DELAY_EN
        // Leave on the edge that completes the frame_delay-th idle cycle.
        S_DELAY: begin
          if (delay_cnt <= CWIDTH'(1)) begin
            delay_cnt <= '0;
            state     <= S_EMIT;
          end else begin
            delay_cnt <= delay_cnt - 1'b1;
          end
        end
`endif
        S_EMIT: begin
          if (disp_ready) begin
            if (run && !stop && (limit_zero || gen_count != target)) begin
              state <= S_COMPUTE;
            end else begin
              run   <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      // NOTE: a later non-blocking assignment to the same register wins, so this overrides any run set above.
      if (stop) run <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conware_scheduler.sv
// Bench for conware_scheduler: plays seed source, compute engine and display sink against a queue-free run model.
// Expected frame latency follows CONWARE_SCHED_FRAME_DELAY_EN as given to the build.
module tb_conware_scheduler;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int CW = 32;
`ifdef CONWARE_SCHED_FRAME_DELAY_EN
  localparam bit DELAY_EN = 1'b1;
`else
  localparam bit DELAY_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn, start, step, stop;
  logic [CW-1:0] gen_limit, frame_delay;
  logic [N-1:0]  seed_data, calc_data, res_data, disp_data;
  logic          seed_valid, seed_ready, calc_valid, calc_ready;
  logic          res_valid, res_ready, disp_valid, disp_ready;
  logic          busy;
  logic [CW-1:0] gen_count;

  always #5 clk = ~clk;

  conware_scheduler #(.WIDTH(W), .HEIGHT(H), .CWIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .step(step), .stop(stop),
    .gen_limit(gen_limit), .frame_delay(frame_delay),
    .seed_data(seed_data), .seed_valid(seed_valid), .seed_ready(seed_ready),
    .calc_data(calc_data), .calc_valid(calc_valid), .calc_ready(calc_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .disp_data(disp_data), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .busy(busy), .gen_count(gen_count)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: what the board and generation count should be after each transfer.
  logic [N-1:0]  model_board;
  logic [CW-1:0] model_gen;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start = 0; step = 0; stop = 0;
    seed_valid = 0; calc_ready = 0; res_valid = 0; disp_ready = 0;
    seed_data = '0; res_data = '0;
    gen_limit = '0; frame_delay = '0;
  endtask

  // Scheduler should be back in IDLE and stay quiet for a few cycles.
  task automatic expect_idle(input string name);
    bit quiet = 1'b1;
    vectors++;
    if ({seed_ready, busy, calc_valid, res_ready, disp_valid} !== 5'b10000 || gen_count !== model_gen) begin
      miscompares++;
      $display("FAIL %s idle: ready/busy/cv/rr/dv=%b gen=%0d expected 10000 gen=%0d",
               name, {seed_ready, busy, calc_valid, res_ready, disp_valid}, gen_count, model_gen);
    end
    repeat (4) begin
      tick;
      if (calc_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    vectors++;
    if (!quiet) begin
      miscompares++;
      $display("FAIL %s quiet: calc_valid or busy rose after returning to IDLE, expected 0", name);
    end
  endtask

  task automatic do_seed(input logic [N-1:0] value, input bit with_start);
    seed_data = value; seed_valid = 1; start = with_start; step = with_start;
    gen_limit = 32'd5;
    tick;
    seed_valid = 0; start = 0; step = 0; seed_data = N'($urandom);
    model_board = value;
    model_gen   = '0;
    vectors++;
    if (disp_valid !== 1'b1 || disp_data !== value || gen_count !== '0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL seed_emit: dv=%b data=%h gen=%0d busy=%b expected dv=1 data=%h gen=0 busy=1",
               disp_valid, disp_data, gen_count, busy, value);
    end
    disp_ready = 1; tick; disp_ready = 0;
    expect_idle("seed");
  endtask

  task automatic do_start(input logic [CW-1:0] limit);
    gen_limit = limit; start = 1;
    tick;
    start = 0;
    gen_limit = $urandom;
  endtask

  // One generation, entered with the scheduler offering the board to the engine.
  task automatic do_gen(input logic [N-1:0] res, input int fd, input int cstall,
                        input int dstall, input bit stop_in_cwait);
    bit stable = 1'b1;
    int extra = 0;
    int exp_extra;
    vectors++;
    if (calc_valid !== 1'b1 || calc_data !== model_board) begin
      miscompares++;
      $display("FAIL calc_offer: valid=%b data=%h expected valid=1 data=%h", calc_valid, calc_data, model_board);
    end
    repeat (cstall) begin
      tick;
      if (calc_valid !== 1'b1 || calc_data !== model_board) stable = 1'b0;
    end
    calc_ready = 1; tick; calc_ready = 0;
    if (stop_in_cwait) begin
      stop = 1; tick; stop = 0;
    end
    tick;
    if (calc_valid !== 1'b0 || res_ready !== 1'b1) stable = 1'b0;
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("FAIL calc_hold: calc offer dropped or res_ready missing, expected held until handshake");
    end
    frame_delay = CW'(fd); res_data = res; res_valid = 1;
    tick;
    res_valid = 0; res_data = N'($urandom); frame_delay = CW'($urandom_range(1, 9));
    model_board = res;
    model_gen   = model_gen + 1'b1;
    exp_extra   = (DELAY_EN && fd != 0) ? fd : 0;
    while (disp_valid !== 1'b1 && extra < 64) begin
      tick;
      extra++;
    end
    vectors++;
    if (extra !== exp_extra) begin
      miscompares++;
      $display("FAIL disp_latency: %0d extra cycles after res handshake, expected %0d", extra, exp_extra);
    end
    vectors++;
    if (disp_data !== model_board || gen_count !== model_gen) begin
      miscompares++;
      $display("FAIL disp_frame: data=%h gen=%0d expected data=%h gen=%0d", disp_data, gen_count, model_board, model_gen);
    end
    stable = 1'b1;
    repeat (dstall) begin
      tick;
      if (disp_valid !== 1'b1 || disp_data !== model_board) stable = 1'b0;
    end
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("FAIL disp_hold: display offer dropped or changed before disp_ready, expected held");
    end
    disp_ready = 1; tick; disp_ready = 0;
  endtask

  task automatic test_reset;
    idle_inputs;
    rstn = 0; tick; tick; rstn = 1;
    model_board = '0; model_gen = '0;
    vectors++;
    if ({seed_ready, busy, calc_valid, res_ready, disp_valid} !== 5'b10000 ||
        gen_count !== '0 || calc_data !== '0) begin
      miscompares++;
      $display("FAIL reset: ready/busy/cv/rr/dv=%b gen=%0d board=%h expected 10000 gen=0 board=0",
               {seed_ready, busy, calc_valid, res_ready, disp_valid}, gen_count, calc_data);
    end
  endtask

  task automatic test_seed;
    do_seed(16'h0660, 1'b0);
    do_seed(16'h0070, 1'b1);
  endtask

  task automatic test_blinker;
    do_seed(16'h0070, 1'b0);
    do_start(32'd3);
    do_gen(16'h2220, 0, 0, 0, 1'b0);
    do_gen(16'h0070, 0, 1, 2, 1'b0);
    do_gen(16'h2220, 0, 0, 1, 1'b0);
    expect_idle("blinker");
  endtask

  task automatic test_step;
    do_seed(16'h0070, 1'b0);
    step = 1; tick; step = 0;
    do_gen(16'h2220, 0, 0, 0, 1'b0);
    expect_idle("step");
  endtask

  task automatic test_stop;
    do_seed(N'($urandom), 1'b0);
    do_start('0);
    do_gen(N'($urandom), 0, 0, 0, 1'b0);
    do_gen(N'($urandom), 0, 0, 0, 1'b0);
    do_gen(N'($urandom), 0, 0, 0, 1'b1);
    expect_idle("stop");
  endtask

  task automatic test_delay;
    do_seed(N'($urandom), 1'b0);
    do_start(32'd2);
    do_gen(N'($urandom), 5, 0, 0, 1'b0);
    do_gen(N'($urandom), 1, 0, 0, 1'b0);
    expect_idle("delay");
  endtask

  // Random runs; runs without reseeding check the limit counts from the current generation.
  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      int gens;
      if (r == 0 || $urandom_range(0, 2) == 0) do_seed(N'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        step = 1; tick; step = 0;
        gens = 1;
      end else begin
        gens = $urandom_range(1, 4);
        do_start(CW'(gens));
      end
      for (int g = 0; g < gens; g++)
        do_gen(N'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
      expect_idle("random");
    end
  endtask

  task automatic test_backpressure_reset;
    bit stable = 1'b1;
    logic [N-1:0] value = N'($urandom) | 16'h0001;
    seed_data = value; seed_valid = 1; tick; seed_valid = 0;
    repeat (10) begin
      if (disp_valid !== 1'b1 || disp_data !== value) stable = 1'b0;
      tick;
    end
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("FAIL bp_hold: display offer not held under disp_ready=0, expected data=%h", value);
    end
    rstn = 0; tick; rstn = 1;
    vectors++;
    if (disp_valid !== 1'b0 || disp_data !== '0 || seed_ready !== 1'b1 || busy !== 1'b0 || gen_count !== '0) begin
      miscompares++;
      $display("FAIL bp_reset: dv=%b board=%h ready=%b busy=%b gen=%0d expected dv=0 board=0 ready=1 busy=0 gen=0",
               disp_valid, disp_data, seed_ready, busy, gen_count);
    end
  endtask

  initial begin
    idle_inputs;
    rstn = 1;
    test_reset;
    test_seed;
    test_blinker;
    test_step;
    test_stop;
    test_delay;
    test_random;
    test_backpressure_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
